mini_src_ctrl_seq: RTL and testbench
====================================

// Module: mini_src_ctrl_seq
// PURPOSE
//  Control-step sequencer for the Mini SRC datapath. Walks T0..T7 per instruction and drives DataPath control strobes.
//  Covers fetch plus ALU-reg, ALU-imm, ld, ldi, st, br, nop and halt. Memory steps wait on a variable-latency ack.
//  Sits beside DataPath; replaces hand-driven step sequences in benches.
// PARAMETERS
//  IR_W    32        instruction width; opcode = ir[IR_W-1 -: OPC_W]
//  OPC_W   5         opcode width
//  ALU_W   5         alu_control width
//  ADD_OP  5'b00011  ALU code for address/immediate add
// PORTS
//  clk          in   1      clock, rising edge
//  clr          in   1      reset, asynchronous, active-low
//  run          in   1      start pulse from IDLE
//  ir           in   IR_W   IR register contents
//  mem_ack      in   1      memory done (read data valid / write taken)
//  con_ff       in   1      branch condition flip-flop
//  Pout,MARen,MDRen,Read,Write,MDROut,IRen,Yen,Zen  out 1 each  datapath strobes
//  ZLOout,ZHIout,LOen,HIen,Cout,BAout,ConIn,Pen,IncPC out 1 each
//  Gra,Grb,Grc,Rin,Rout  out 1 each  select-and-encode controls
//  alu_control  out  ALU_W  ALU op for the Zen step, else 0
//  step         out  4      state code: IDLE=0, T0..T7=1..8, HALT=15
//  busy,halted  out  1      busy = not IDLE/HALT; halted = in HALT
// BEHAVIOUR
//  - State is registered; all outputs decode combinationally from state, ir, mem_ack and con_ff.
//  - clr low: state goes to IDLE immediately; every output is 0, including mid-instruction.
//  - IDLE -> T0 on run=1; run ignored elsewhere. HALT is exited only by clr.
//  - ir is stable from T3 on because IRen fires only in T2. Opcode is decoded each cycle from ir.
//  - Fetch: T0 Pout MARen IncPC Zen. T1 Read MDRen held until mem_ack=1; in the ack cycle also ZLOout Pen. T2 MDROut IRen.
//  - ALU-reg (add..rol): T3 Grb Rout Yen; T4 Grc Rout Zen alu_control=op; T5 ZLOout Gra Rin.
//  - ALU-imm (addi/andi/ori): T3 Grb Rout Yen; T4 Cout Zen alu=add/and/or code; T5 ZLOout Gra Rin.
//  - ldi: as ALU-imm with BAout instead of Rout in T3; alu=ADD_OP.
//  - ld: T3 Grb BAout Yen; T4 Cout Zen ADD_OP; T5 ZLOout MARen; T6 Read MDRen until ack; T7 MDROut Gra Rin.
//  - st: T3-T5 as ld; T6 Gra Rout MDRen (Read=0); T7 Write held until ack.
//  - br: T3 Gra Rout ConIn; T4 Pout Yen; T5 Cout Zen ADD_OP; T6 ZLOout, plus Pen only if con_ff=1.
//  - Last step of each class -> T0 next edge. nop and unsupported opcodes -> T0 after T2.
//  - halt: after T2, enter HALT.
//  - Wait steps (T1, ld T6, st T7) are 1 cycle if mem_ack is already high. mem_ack is ignored in other steps.
//  - Pen/ZLOout in T1 pulse exactly once per fetch, regardless of wait length.
// CONFIGURATION
//  MINI_SRC_MULDIV_EN defined: mul/div sequence.
//   T3 Gra Rout Yen; T4 Grb Rout Zen alu=op; T5 ZLOout LOen; T6 ZHIout HIen; then T0.
//  MINI_SRC_MULDIV_EN undefined: mul/div decode as nop; LOen, HIen, ZHIout are tied 0.
// STRUCTURE
//  - Package mini_src_pkg holds opcode constants, ALU codes, state codes and the instruction-class enum.
//  - Sub-module mini_src_opdecode: combinational opcode -> {class, alu_control}.
//  - Top holds the state register, next-state logic and output decode.
// TESTING
//  1. mem_ack=1, ir=0x61A7FFFB (addi R3,R4,-5), run pulse -> T0..T5 in 6 cycles.
//     T4 Cout Zen alu_control=5'b00011; T5 ZLOout Gra Rin; T0 follows.
//  2. Fetch with mem_ack low 3 cycles in T1 -> Read/MDRen high 4 cycles; ZLOout and Pen high only in the 4th.
//  3. ir=0x00800055 (ld R1,0x55(R0)) -> T3 BAout Grb Yen; T6 stalls 2 cycles with mem_ack low; T7 MDROut Gra Rin.
//  4. st: T7 Write held until ack -> Write deasserts in the cycle after ack; st at T6 asserts MDRen with Read=0.
//  5. br run twice, con_ff=0 then 1 -> Pen absent in first T6, present in second.
//  6. mul with/without MINI_SRC_MULDIV_EN -> LOen at T5, HIen at T6 / 3-step nop.
//     halt -> halted=1, run ignored. clr low during T4 -> all outputs 0 same cycle, step=0.

Source files
------------

// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - Mini SRC opcode, ALU code, step code and instruction-class definitions.
package mini_src_pkg;

  localparam int IR_W  = 32;
  localparam int OPC_W = 5;
  localparam int ALU_W = 5;

  localparam logic [ALU_W-1:0] ADD_OP = 5'b00011;
  localparam logic [ALU_W-1:0] AND_OP = 5'b00101;
  localparam logic [ALU_W-1:0] OR_OP  = 5'b00110;

  localparam logic [OPC_W-1:0] OPC_LD   = 5'd0;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'd1;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'd2;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'd11;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'd12;
  localparam logic [OPC_W-1:0] OPC_ANDI = 5'd13;
  localparam logic [OPC_W-1:0] OPC_ORI  = 5'd14;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'd15;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'd16;
  localparam logic [OPC_W-1:0] OPC_BR   = 5'd19;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'd26;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'd27;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd15
  } step_e;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU_REG,
    CL_ALU_IMM,
    CL_LDI,
    CL_LD,
    CL_ST,
    CL_BR,
    CL_MULDIV,
    CL_HALT
  } iclass_e;

  typedef struct packed {
    logic pout;
    logic mar_en;
    logic mdr_en;
    logic read;
    logic write;
    logic mdr_out;
    logic ir_en;
    logic y_en;
    logic z_en;
    logic zlo_out;
    logic zhi_out;
    logic lo_en;
    logic hi_en;
    logic c_out;
    logic ba_out;
    logic con_in;
    logic p_en;
    logic inc_pc;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } strobes_t;

endpackage

// File: rtl/mini_src_ctrl_seq_if.sv
// rtl/mini_src_ctrl_seq_if.sv - Sequencer-to-datapath control bundle with master/slave modports.
interface mini_src_ctrl_seq_if;
  import mini_src_pkg::*;

  logic             run;
  logic [IR_W-1:0]  ir;
  logic             mem_ack;
  logic             con_ff;

  logic Pout, MARen, MDRen, Read, Write, MDROut, IRen, Yen, Zen;
  logic ZLOout, ZHIout, LOen, HIen, Cout, BAout, ConIn, Pen, IncPC;
  logic Gra, Grb, Grc, Rin, Rout;
  logic [ALU_W-1:0] alu_control;
  logic [3:0]       step;
  logic             busy;
  logic             halted;

  modport master (
    input  run, ir, mem_ack, con_ff,
    output Pout, MARen, MDRen, Read, Write, MDROut, IRen, Yen, Zen,
    output ZLOout, ZHIout, LOen, HIen, Cout, BAout, ConIn, Pen, IncPC,
    output Gra, Grb, Grc, Rin, Rout, alu_control, step, busy, halted
  );

  modport slave (
    output run, ir, mem_ack, con_ff,
    input  Pout, MARen, MDRen, Read, Write, MDROut, IRen, Yen, Zen,
    input  ZLOout, ZHIout, LOen, HIen, Cout, BAout, ConIn, Pen, IncPC,
    input  Gra, Grb, Grc, Rin, Rout, alu_control, step, busy, halted
  );

endinterface

// File: rtl/mini_src_opdecode.sv
// rtl/mini_src_opdecode.sv - Opcode to {instruction class, ALU code}; mul/div only with MINI_SRC_MULDIV_EN.
module mini_src_opdecode
  import mini_src_pkg::*;
(
  input  logic [OPC_W-1:0] opc_i,
  output iclass_e          class_o,
  output logic [ALU_W-1:0] alu_o
);

  always_comb begin
    class_o = CL_NOP;
    alu_o   = '0;
    // Register ALU ops share their opcode value with the ALU code.
    if (opc_i >= OPC_ADD && opc_i <= OPC_ROL) begin
      class_o = CL_ALU_REG;
      alu_o   = opc_i;
    end else begin
      case (opc_i)
        OPC_LD:   begin class_o = CL_LD;      alu_o = ADD_OP; end
        OPC_LDI:  begin class_o = CL_LDI;     alu_o = ADD_OP; end
        OPC_ST:   begin class_o = CL_ST;      alu_o = ADD_OP; end
        OPC_ADDI: begin class_o = CL_ALU_IMM; alu_o = ADD_OP; end
        OPC_ANDI: begin class_o = CL_ALU_IMM; alu_o = AND_OP; end
        OPC_ORI:  begin class_o = CL_ALU_IMM; alu_o = OR_OP;  end
        OPC_BR:   begin class_o = CL_BR;      alu_o = ADD_OP; end
        OPC_HALT: begin class_o = CL_HALT; end
`ifdef MINI_SRC_MULDIV_EN
        OPC_MUL, OPC_DIV: begin class_o = CL_MULDIV; alu_o = opc_i; end
`endif
        default:  begin class_o = CL_NOP; end
      endcase
    end
  end

endmodule

// File: rtl/mini_src_ctrl_seq.sv
// rtl/mini_src_ctrl_seq.sv - Mini SRC T0..T7 control-step sequencer; MINI_SRC_MULDIV_EN adds the mul/div sequence.
module mini_src_ctrl_seq
  import mini_src_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  mini_src_ctrl_seq_if.master bus
);

  step_e            state_q, state_d;
  strobes_t         ctl;
  logic [ALU_W-1:0] alu_ctl;
  iclass_e          cls;
  logic [ALU_W-1:0] dec_alu;
  logic [OPC_W-1:0] opc;
  logic             unused_ir_bits;

  assign opc            = bus.ir[IR_W-1 -: OPC_W];
  assign unused_ir_bits = ^bus.ir[IR_W-OPC_W-1:0];

  mini_src_opdecode u_opdecode (
    .opc_i   (opc),
    .class_o (cls),
    .alu_o   (dec_alu)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    alu_ctl = '0;
    case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_T0;
      ST_T0: begin
        ctl.pout = 1'b1; ctl.mar_en = 1'b1; ctl.inc_pc = 1'b1; ctl.z_en = 1'b1;
        state_d = ST_T1;
      end
      // PC write-back only in the ack cycle so it fires once per fetch.
      ST_T1: begin
        ctl.read = 1'b1; ctl.mdr_en = 1'b1;
        if (bus.mem_ack) begin
          ctl.zlo_out = 1'b1; ctl.p_en = 1'b1;
          state_d = ST_T2;
        end
      end
      ST_T2: begin
        ctl.mdr_out = 1'b1; ctl.ir_en = 1'b1;
        case (cls)
          CL_NOP:  state_d = ST_T0;
          CL_HALT: state_d = ST_HALT;
          default: state_d = ST_T3;
        endcase
      end
      ST_T3: begin
        state_d = ST_T4;
        case (cls)
          CL_ALU_REG, CL_ALU_IMM: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_en = 1'b1; end
          CL_LDI, CL_LD, CL_ST:   begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_en = 1'b1; end
          CL_BR:                  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; end
`ifdef MINI_SRC_MULDIV_EN
          CL_MULDIV:              begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_en = 1'b1; end
`endif
          default:                state_d = ST_T0;
        endcase
      end
      ST_T4: begin
        state_d = ST_T5;
        case (cls)
          CL_ALU_REG: begin ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_en = 1'b1; alu_ctl = dec_alu; end
          CL_ALU_IMM, CL_LDI, CL_LD, CL_ST: begin ctl.c_out = 1'b1; ctl.z_en = 1'b1; alu_ctl = dec_alu; end
          CL_BR:      begin ctl.pout = 1'b1; ctl.y_en = 1'b1; end
`ifdef MINI_SRC_MULDIV_EN
          CL_MULDIV:  begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_en = 1'b1; alu_ctl = dec_alu; end
`endif
          default:    state_d = ST_T0;
        endcase
      end
      ST_T5: begin
        state_d = ST_T6;
        case (cls)
          CL_ALU_REG, CL_ALU_IMM, CL_LDI: begin
            ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
            state_d = ST_T0;
          end
          CL_LD, CL_ST: begin ctl.zlo_out = 1'b1; ctl.mar_en = 1'b1; end
          CL_BR:        begin ctl.c_out = 1'b1; ctl.z_en = 1'b1; alu_ctl = ADD_OP; end
`ifdef MINI_SRC_MULDIV_EN
          CL_MULDIV:    begin ctl.zlo_out = 1'b1; ctl.lo_en = 1'b1; end
`endif
          default:      state_d = ST_T0;
        endcase
      end
      ST_T6: begin
        state_d = ST_T0;
        case (cls)
          CL_LD: begin
            ctl.read = 1'b1; ctl.mdr_en = 1'b1;
            state_d = bus.mem_ack ? ST_T7 : ST_T6;
          end
          CL_ST: begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_en = 1'b1;
            state_d = ST_T7;
          end
          CL_BR: begin ctl.zlo_out = 1'b1; ctl.p_en = bus.con_ff; end
`ifdef MINI_SRC_MULDIV_EN
          CL_MULDIV: begin ctl.zhi_out = 1'b1; ctl.hi_en = 1'b1; end
`endif
          default: state_d = ST_T0;
        endcase
      end
      ST_T7: begin
        state_d = ST_T0;
        case (cls)
          CL_LD: begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          CL_ST: begin
            ctl.write = 1'b1;
            state_d = bus.mem_ack ? ST_T0 : ST_T7;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.Pout        = ctl.pout;
  assign bus.MARen       = ctl.mar_en;
  assign bus.MDRen       = ctl.mdr_en;
  assign bus.Read        = ctl.read;
  assign bus.Write       = ctl.write;
  assign bus.MDROut      = ctl.mdr_out;
  assign bus.IRen        = ctl.ir_en;
  assign bus.Yen         = ctl.y_en;
  assign bus.Zen         = ctl.z_en;
  assign bus.ZLOout      = ctl.zlo_out;
  assign bus.ZHIout      = ctl.zhi_out;
  assign bus.LOen        = ctl.lo_en;
  assign bus.HIen        = ctl.hi_en;
  assign bus.Cout        = ctl.c_out;
  assign bus.BAout       = ctl.ba_out;
  assign bus.ConIn       = ctl.con_in;
  assign bus.Pen         = ctl.p_en;
  assign bus.IncPC       = ctl.inc_pc;
  assign bus.Gra         = ctl.gra;
  assign bus.Grb         = ctl.grb;
  assign bus.Grc         = ctl.grc;
  assign bus.Rin         = ctl.r_in;
  assign bus.Rout        = ctl.r_out;
  assign bus.alu_control = alu_ctl;
  assign bus.step        = state_q;
  assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_mini_src_ctrl_seq.sv
// tb/tb_mini_src_ctrl_seq.sv - Self-checking bench for mini_src_ctrl_seq.
module tb_mini_src_ctrl_seq;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mini_src_ctrl_seq_if bus ();

  mini_src_ctrl_seq dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  step;
    logic [22:0] mask;
    logic [4:0]  alu;
    bit          ack;
  } cyc_t;

  typedef struct {
    logic [31:0] ir;
    bit          con;
    int          wf;
    int          wm;
    int          ncyc;
    int          npen;
    logic [3:0]  endst;
  } vec_t;

  cyc_t mq[$];
  vec_t vt[$];

  string names [0:22] = '{"Pout", "MARen", "MDRen", "Read", "Write", "MDROut", "IRen", "Yen",
                          "Zen", "ZLOout", "ZHIout", "LOen", "HIen", "Cout", "BAout", "ConIn",
                          "Pen", "IncPC", "Gra", "Grb", "Grc", "Rin", "Rout"};

  function automatic logic [22:0] act_mask();
    return {bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.IncPC, bus.Pen, bus.ConIn,
            bus.BAout, bus.Cout, bus.HIen, bus.LOen, bus.ZHIout, bus.ZLOout, bus.Zen, bus.Yen,
            bus.IRen, bus.MDROut, bus.Write, bus.Read, bus.MDRen, bus.MARen, bus.Pout};
  endfunction

  // Turns a space-separated list of strobe names into a bit mask.
  function automatic logic [22:0] smask(input string s);
    logic [22:0] m;
    string tok;
    m = '0;
    tok = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        for (int k = 0; k < 23; k++)
          if (tok.len() > 0 && tok == names[k]) m[k] = 1'b1;
        tok = "";
      end else begin
        tok = {tok, s.substr(i, i)};
      end
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int st, input string s, input int alu, input int ack);
    cyc_t c;
    c.step = 4'(st);
    c.mask = smask(s);
    c.alu  = 5'(alu);
    c.ack  = (ack < 0) ? 1'($urandom % 2) : (ack != 0);
    mq.push_back(c);
  endtask

  // Micro-program of one instruction as a list of expected cycles.
  task automatic build_model(input logic [31:0] ir_v, input bit con, input int wf, input int wm,
                             output logic [3:0] end_step);
    int opc;
    opc = int'(ir_v[31:27]);
    mq.delete();
    end_step = 4'd1;
    push(1, "Pout MARen IncPC Zen", 0, -1);
    repeat (wf) push(2, "Read MDRen", 0, 0);
    push(2, "Read MDRen ZLOout Pen", 0, 1);
    push(3, "MDROut IRen", 0, -1);
    if (opc >= 3 && opc <= 11) begin
      push(4, "Grb Rout Yen", 0, -1);
      push(5, "Grc Rout Zen", opc, -1);
      push(6, "ZLOout Gra Rin", 0, -1);
    end else if (opc >= 12 && opc <= 14) begin
      push(4, "Grb Rout Yen", 0, -1);
      push(5, "Cout Zen", (opc == 12) ? 3 : (opc == 13) ? 5 : 6, -1);
      push(6, "ZLOout Gra Rin", 0, -1);
    end else if (opc == 1) begin
      push(4, "Grb BAout Yen", 0, -1);
      push(5, "Cout Zen", 3, -1);
      push(6, "ZLOout Gra Rin", 0, -1);
    end else if (opc == 0 || opc == 2) begin
      push(4, "Grb BAout Yen", 0, -1);
      push(5, "Cout Zen", 3, -1);
      push(6, "ZLOout MARen", 0, -1);
      if (opc == 0) begin
        repeat (wm) push(7, "Read MDRen", 0, 0);
        push(7, "Read MDRen", 0, 1);
        push(8, "MDROut Gra Rin", 0, -1);
      end else begin
        push(7, "Gra Rout MDRen", 0, -1);
        repeat (wm) push(8, "Write", 0, 0);
        push(8, "Write", 0, 1);
      end
    end else if (opc == 19) begin
      push(4, "Gra Rout ConIn", 0, -1);
      push(5, "Pout Yen", 0, -1);
      push(6, "Cout Zen", 3, -1);
      push(7, con ? "ZLOout Pen" : "ZLOout", 0, -1);
`ifdef MINI_SRC_MULDIV_EN
    end else if (opc == 15 || opc == 16) begin
      push(4, "Gra Rout Yen", 0, -1);
      push(5, "Grb Rout Zen", opc, -1);
      push(6, "ZLOout LOen", 0, -1);
      push(7, "ZHIout HIen", 0, -1);
`endif
    end else if (opc == 27) begin
      end_step = 4'd15;
    end
  endtask

  // Runs one instruction starting in T0, checking every cycle against the model.
  task automatic run_instr(input logic [31:0] ir_v, input bit con, input int wf, input int wm,
                           output int ncyc, output int npen, output logic [3:0] endst);
    logic [3:0] exp_end;
    build_model(ir_v, con, wf, wm, exp_end);
    bus.ir     = ir_v;
    bus.con_ff = con;
    ncyc = 0;
    npen = 0;
    foreach (mq[i]) begin
      bus.mem_ack = mq[i].ack;
      bus.run     = 1'($urandom % 2);
      @(negedge clk);
      check($sformatf("ir=%h cyc%0d step", ir_v, i), 32'(bus.step), 32'(mq[i].step));
      check($sformatf("ir=%h cyc%0d strobes", ir_v, i), 32'(act_mask()), 32'(mq[i].mask));
      check($sformatf("ir=%h cyc%0d alu", ir_v, i), 32'(bus.alu_control), 32'(mq[i].alu));
      check($sformatf("ir=%h cyc%0d busy", ir_v, i), 32'(bus.busy), 32'd1);
      npen += int'(bus.Pen);
      ncyc++;
      @(posedge clk);
      #1;
    end
    bus.run = 1'b0;
    endst = bus.step;
    check($sformatf("ir=%h end step", ir_v), 32'(bus.step), 32'(exp_end));
  endtask

  task automatic run_pulse();
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    check("run pulse -> T0", 32'(bus.step), 32'd1);
  endtask

  initial begin
    int ncyc, npen;
    logic [3:0] endst;
    logic [4:0] opc;
    logic [31:0] ir_v;

    vt.push_back('{32'h61A7FFFB, 1'b0, 0, 0, 6,  1, 4'd1});  // addi
    vt.push_back('{32'hD0000000, 1'b0, 3, 0, 6,  1, 4'd1});  // nop, 3-cycle fetch wait
    vt.push_back('{32'h00800055, 1'b0, 0, 2, 10, 1, 4'd1});  // ld, 2 stall cycles
    vt.push_back('{32'h10000000, 1'b0, 1, 1, 10, 1, 4'd1});  // st
    vt.push_back('{32'h98000000, 1'b0, 0, 0, 7,  1, 4'd1});  // br not taken
    vt.push_back('{32'h98000000, 1'b1, 0, 0, 7,  2, 4'd1});  // br taken
    vt.push_back('{32'h18000000, 1'b0, 2, 0, 8,  1, 4'd1});  // add
`ifdef MINI_SRC_MULDIV_EN
    vt.push_back('{32'h78000000, 1'b0, 0, 0, 7,  1, 4'd1});  // mul
`else
    vt.push_back('{32'h78000000, 1'b0, 0, 0, 3,  1, 4'd1});  // mul as nop
`endif
    vt.push_back('{32'h08000000, 1'b0, 0, 0, 6,  1, 4'd1});  // ldi
    vt.push_back('{32'hF8000000, 1'b0, 0, 0, 3,  1, 4'd1});  // unsupported

    clr = 1'b0;
    bus.run = 1'b0;
    bus.ir = '0;
    bus.mem_ack = 1'b0;
    bus.con_ff = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset step", 32'(bus.step), 32'd0);
    check("reset strobes", 32'(act_mask()), 32'd0);
    check("reset alu", 32'(bus.alu_control), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset halted", 32'(bus.halted), 32'd0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("idle holds without run", 32'(bus.step), 32'd0);
    run_pulse();

    foreach (vt[i]) begin
      run_instr(vt[i].ir, vt[i].con, vt[i].wf, vt[i].wm, ncyc, npen, endst);
      check($sformatf("vec%0d cycles", i), 32'(ncyc), 32'(vt[i].ncyc));
      check($sformatf("vec%0d pen count", i), 32'(npen), 32'(vt[i].npen));
      check($sformatf("vec%0d end step", i), 32'(endst), 32'(vt[i].endst));
    end

    for (int n = 0; n < 40; n++) begin
      do opc = 5'($urandom); while (opc == 5'd27);
      ir_v = {opc, 27'($urandom)};
      run_instr(ir_v, 1'($urandom % 2), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ncyc, npen, endst);
    end

    // clr mid-instruction: outputs drop in the same cycle.
    bus.ir = 32'h61A7FFFB;
    bus.mem_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reached T4 before clr", 32'(bus.step), 32'd5);
    clr = 1'b0;
    #1;
    check("clr step", 32'(bus.step), 32'd0);
    check("clr strobes", 32'(act_mask()), 32'd0);
    check("clr alu", 32'(bus.alu_control), 32'd0);
    check("clr busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("idle after clr", 32'(bus.step), 32'd0);

    run_pulse();
    run_instr(32'hD8000000, 1'b0, 1, 0, ncyc, npen, endst);
    check("halt cycles", 32'(ncyc), 32'd4);
    check("halted flag", 32'(bus.halted), 32'd1);
    check("halt busy", 32'(bus.busy), 32'd0);
    check("halt strobes", 32'(act_mask()), 32'd0);
    bus.run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.run = 1'b0;
    check("halt ignores run", 32'(bus.step), 32'd15);
    clr = 1'b0;
    #1;
    check("clr exits halt", 32'(bus.step), 32'd0);
    check("clr clears halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    clr = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
